// File: rtl/rv_enc_pkg.sv
// Shared types and RV32I field constants for the instruction encoder.
// encode() packs one symbolic request into a word and flags illegal requests.
package rv_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_ADDI = 5'd8,  OP_ANDI = 5'd9,  OP_ORI  = 5'd10, OP_XORI = 5'd11,
    OP_SLLI = 5'd12, OP_SRLI = 5'd13, OP_SRAI = 5'd14, OP_LW   = 5'd15,
    OP_JALR = 5'd16, OP_SW   = 5'd17, OP_BEQ  = 5'd18, OP_BNE  = 5'd19,
    OP_BLT  = 5'd20, OP_BGE  = 5'd21, OP_LUI  = 5'd22, OP_JAL  = 5'd23
  } op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_res_t;

  function automatic enc_res_t encode(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm);
    enc_res_t          r;
    logic signed [31:0] simm;
    logic [2:0]        f3;
    logic [6:0]        f7;
    simm      = imm;
    r.word    = '0;
    r.illegal = 1'b0;
    f7 = (op == OP_SUB || op == OP_SRA || op == OP_SRAI) ? F7_ALT : F7_BASE;
    case (op)
      OP_SLL, OP_SLLI:         f3 = F3_SLL;
      OP_LW, OP_SW:            f3 = F3_WORD;
      OP_XOR, OP_XORI:         f3 = F3_XOR;
      OP_SRL, OP_SRA, OP_SRLI, OP_SRAI: f3 = F3_SR;
      OP_OR, OP_ORI:           f3 = F3_OR;
      OP_AND, OP_ANDI:         f3 = F3_AND;
      OP_BNE:                  f3 = F3_BNE;
      OP_BLT:                  f3 = F3_BLT;
      OP_BGE:                  f3 = F3_BGE;
      default:                 f3 = F3_ADD;
    endcase
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA:
        r.word = {f7, rs2, rs1, f3, rd, OPC_OP};
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        r.illegal = (simm < -2048) || (simm > 2047);
        r.word    = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        r.illegal = (simm < 0) || (simm > 31);
        r.word    = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
      end
      OP_LW, OP_JALR: begin
        r.illegal = (simm < -2048) || (simm > 2047);
        r.word    = {imm[11:0], rs1, f3, rd, (op == OP_LW) ? OPC_LOAD : OPC_JALR};
      end
      OP_SW: begin
        r.illegal = (simm < -2048) || (simm > 2047);
        r.word    = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        r.illegal = (simm < -4096) || (simm > 4094) || imm[0];
        r.word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      OP_LUI: begin
        r.illegal = (imm[11:0] != 12'd0);
        r.word    = {imm[31:12], rd, OPC_LUI};
      end
      OP_JAL: begin
        r.illegal = (simm < -1048576) || (simm > 1048574) || imm[0];
        r.word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      default: r.illegal = 1'b1;
    endcase
    if (r.illegal) r.word = '0;
    return r;
  endfunction

endpackage

// File: rtl/rv32_instr_encoder_fifo.sv
// DEPTH x WIDTH synchronous FIFO; pointers carry an extra wrap bit so full
// and empty are told apart by the MSB.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Storage is cleared too, so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Packs symbolic RV32I requests into instruction words and streams them out
// through a small FIFO; illegal requests are consumed, counted and never emitted.
module rv32_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] enc_cnt
);
  import rv_enc_pkg::*;

  enc_res_t         enc;
  logic             full, empty, acc, push, pop;
  logic             err_d, err_q;
  logic [7:0]       err_cnt_d, err_cnt_q;
  logic [CNT_W-1:0] enc_cnt_d, enc_cnt_q;

  always_comb enc = encode(req_op, req_rd, req_rs1, req_rs2, req_imm);

  // No pass-through: a pop in the same cycle does not reopen a full FIFO.
  assign req_ready = !full;
  assign acc       = req_valid && req_ready;
  assign push      = acc && !enc.illegal;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    err_d     = acc && enc.illegal;
    err_cnt_d = err_cnt_q;
    enc_cnt_d = enc_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    if (pop) enc_cnt_d = enc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      enc_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign enc_cnt = enc_cnt_q;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (out_instr),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: expected words queued at acceptance,
// compared in order as the DUT hands them out.
module tb_rv32_instr_encoder;
  import rv_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_op, req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] enc_cnt;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv32_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .err_cnt(err_cnt), .enc_cnt(enc_cnt)
  );

  // Output monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_pulses++;
      if (out_valid && out_ready) begin
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h want none", out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_instr !== e) begin
            errors++;
            $display("FAIL out_instr got %h want %h", out_instr, e);
          end
        end
      end
    end
  end

  function automatic logic [31:0] addi_word(input int i);
    logic [31:0] w;
    w = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
    return w;
  endfunction

  // Called and returns at posedge+1; leaves req_valid low after acceptance.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic legal, input logic [31:0] exp);
    bit ok = 0;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got req_ready=0 want 1");
      req_valid = 1'b0;
      return;
    end
    if (legal) exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!legal) begin
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", err); end
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_req_ready got %b want 1", tag, req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid got %b want 0", tag, out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL %s_out_instr got %h want 0", tag, out_instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s_err got %b want 0", tag, err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL %s_err_cnt got %0d want 0", tag, err_cnt); end
    checks++; if (enc_cnt !== 16'd0) begin errors++; $display("FAIL %s_enc_cnt got %0d want 0", tag, enc_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    out_ready = 1'b0;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency got %b want 1", out_valid); end
    checks++; if (out_instr !== 32'h00500093) begin errors++; $display("FAIL addi_head got %h want 00500093", out_instr); end
    out_ready = 1'b1;
    wait_drain();
    checks++; if (enc_cnt !== 16'd1) begin errors++; $display("FAIL addi_enc_cnt got %0d want 1", enc_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3);
    wait_drain();
    checks++; if (enc_cnt !== 16'd3) begin errors++; $display("FAIL b2b_enc_cnt got %0d want 3", enc_cnt); end
  endtask

  task automatic test_forms();
    out_ready = 1'b1;
    send(OP_SW,   5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423);
    send(OP_LW,   5'd6, 5'd2, 5'd0, -32'sd4,      1'b1, 32'hFFC12303);
    send(OP_SRAI, 5'd4, 5'd4, 5'd0, 32'd3,        1'b1, 32'h40325213);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, -32'sd4,      1'b1, 32'hFE208EE3);
    send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd8,        1'b1, 32'h008000EF);
    send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047,     1'b1, 32'h7FF00093);
    wait_drain();
    checks++; if (enc_cnt !== 16'd10) begin errors++; $display("FAIL forms_enc_cnt got %0d want 10", enc_cnt); end
  endtask

  task automatic test_illegal();
    int p0;
    logic [15:0] c0;
    p0 = err_pulses; c0 = enc_cnt;
    out_ready = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,    1'b0, 32'h0);
    send(5'd31,   5'd1, 5'd1, 5'd1, 32'd0,    1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_pulses - p0 !== 3) begin errors++; $display("FAIL illegal_err_cycles got %0d want 3", err_pulses - p0); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL illegal_err_cnt got %0d want 3", err_cnt); end
    checks++; if (enc_cnt !== c0) begin errors++; $display("FAIL illegal_enc_cnt got %0d want %0d", enc_cnt, c0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i), 1'b1, addi_word(i));
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %b want 0", req_ready); end
    req_valid = 1'b1; req_op = OP_ADDI; req_rd = 5'd5; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL held_req_ready got %b want 0", req_ready); end
    checks++; if (out_instr !== addi_word(1)) begin errors++; $display("FAIL held_head got %h want %h", out_instr, addi_word(1)); end
    checks++; if (enc_cnt !== 16'd10) begin errors++; $display("FAIL held_enc_cnt got %0d want 10", enc_cnt); end
    exp_q.push_back(addi_word(5));
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL no_passthru got %b want 0", req_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reopen got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL refill got %b want 0", req_ready); end
    checks++; if (enc_cnt !== 16'd11) begin errors++; $display("FAIL bp_enc_cnt got %0d want 11", enc_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_idle_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    wait_drain();
    checks++; if (enc_cnt !== 16'd1) begin errors++; $display("FAIL post_reset_enc_cnt got %0d want 1", enc_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL post_reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_forms();
    test_illegal();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Encoder counterpart to the pipelined CPU's instruction decode stage. It accepts symbolic operation requests (operation, register indices, immediate), packs them into 32-bit RV32I instruction words, buffers them in a small FIFO and streams them to the instruction-memory loader or trace-replay harness. It covers exactly the instruction subset the decode stage supports. Illegal requests are consumed and flagged, never emitted.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the emitted-word counter.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_op`  in  5  operation code (`op_t` from package).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices; unused fields are ignored and encoded as zero.
- `req_imm`  in  32  signed immediate (byte offset for branch/jal; full upper value for lui).
- `out_valid`  out  1  `out_instr` holds a valid word.
- `out_ready`  in  1  consumer takes the word when `out_valid & out_ready`.
- `out_instr`  out  32  encoded instruction word.
- `err`  out  1  one-cycle pulse: the last accepted request was illegal.
- `err_cnt`  out  8  illegal-request count; saturates at 255.
- `enc_cnt`  out  CNT_W  count of words emitted on `out`; wraps modulo 2^CNT_W.

## Operation
- Supported ops:
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI.
  - Others: LW, JALR, SW, BEQ, BNE, BLT, BGE, LUI, JAL.
  - Any other `req_op` value is illegal.
- Encoding:
  - Standard RV32I field placement for each op.
  - funct7 is 0100000 for SUB, SRA and SRAI, and 0000000 otherwise.
  - LW uses funct3 010 and SW uses funct3 010.
  - Branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101.
- Immediate legality (a violation makes the request illegal):
  - I/LW/JALR/SW: value in [-2048, 2047].
  - Shifts: value in [0, 31].
  - Branch: value in [-4096, 4094] and even.
  - JAL: value in [-2^20, 2^20-2] and even.
  - LUI: `req_imm[11:0]` is 0; `instr[31:12] = req_imm[31:12]`.
- Accepted legal request: the encoded word is written to the FIFO on the acceptance edge.
- Accepted illegal request:
  - Nothing is written to the FIFO.
  - `err` = 1 in the following cycle.
  - `err_cnt` increments, saturating at 255.
- `req_ready = !full`. There is no pass-through when full: a simultaneous pop does not reopen `req_ready` in that cycle.
- `out_valid = !empty`. `out_instr` is the FIFO head. FIFO order is strict.
- `enc_cnt` increments on every `out` handshake.

## Timing
- Reset values:
  - `req_ready` = 1; `out_valid` = 0; `out_instr` = 0.
  - `err` = 0; `err_cnt` = 0; `enc_cnt` = 0.
  - FIFO pointers = 0.
- Latency:
  - A legal request accepted at edge N appears on `out_valid`/`out_instr` after edge N, i.e. one cycle later, when the FIFO was empty.
  - Otherwise it appears after all earlier entries have drained.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and both complete.
- Full: `req_ready` = 0 and a held `req_valid` is not consumed. `req_*` must stay stable while `req_valid & !req_ready`.
- Empty: a pop is impossible; `out_instr` holds the last read-slot value, which is don't-care.
- Pointer wrap-around: pointers are log2(DEPTH)+1 bits. Full and empty are distinguished by the MSB.
- Reset asserted mid-stream: FIFO contents are discarded and all outputs return to reset values immediately (asynchronous).

## Structure
- Package `rv_enc_pkg`:
  - `op_t` enum (5-bit).
  - RV32I opcode constants: OP 0110011, OP_IMM 0010011, LOAD 0000011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111.
  - funct3 and funct7 constants.
- Combinational encode function/process: produces `{word, illegal}`.
- Sub-module `instr_fifo`: parameterised DEPTH × 32-bit synchronous FIFO with full/empty flags.

## Test plan
- ADDI rd=1, rs1=0, imm=5 → `out_instr` 0x00500093 one cycle after acceptance; `enc_cnt` = 1 after the pop.
- ADD 3,1,2 then SUB 3,1,2 back-to-back → 0x002081B3 then 0x402081B3, in order.
- Store, load and shift forms:
  - SW rs2=2, rs1=1, imm=8 → 0x0020A423.
  - LW rd=6, rs1=2, imm=-4 → 0xFFC12303.
  - SRAI 4,4,3 → 0x40325213.
- Branch and jump forms:
  - BEQ rs1=1, rs2=2, imm=-4 → 0xFE208EE3.
  - JAL rd=1, imm=8 → 0x008000EF.
  - LUI rd=5, imm=0x12345000 → 0x123452B7.
- Illegal requests: ADDI imm=2048, BEQ imm=3, undefined op → each accepted, no output word, one `err` pulse each, `err_cnt` = 3.
- Backpressure: `out_ready` = 0 with 5 legal requests →
  - `req_ready` drops after 4.
  - Reset mid-stream clears all outputs and counters.
  - After reset, a new request emits normally.
